// File: rtl/param_seq_fsm_pkg.sv
// param_seq_fsm_pkg: shared types and the step helper
// for the parametrised cyclic state sequencer.
package param_seq_fsm_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } seq_dir_e;

  // Stepped index plus a flag set when the step wraps.
  typedef struct packed {
    logic        wrap;
    logic [31:0] idx;
  } seq_step_t;

  // One step around the ring of num_states indices.
  function automatic seq_step_t next_state(
    input logic [31:0] cur,
    input seq_dir_e    dir,
    input logic [31:0] num_states
  );
    seq_step_t r;
    r.wrap = 1'b0;
    r.idx  = cur;
    case (dir)
      DIR_UP: begin
        if (cur >= num_states - 32'd1) begin
          r.idx  = '0;
          r.wrap = 1'b1;
        end else begin
          r.idx = cur + 32'd1;
        end
      end
      default: begin
        if (cur == 32'd0) begin
          r.idx  = num_states - 32'd1;
          r.wrap = 1'b1;
        end else begin
          r.idx = cur - 32'd1;
        end
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/param_seq_fsm_dwell.sv
// seq_dwell_counter: counts extra hold cycles per state
// and flags the enabled cycle on which the state may step.
module seq_dwell_counter
  import param_seq_fsm_pkg::*;
#(
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clear,
  input  logic [DWELL_W-1:0] dwell,
  output logic               step
);

  logic [DWELL_W-1:0] cnt_q;
  logic [DWELL_W-1:0] cnt_d;
  logic               hit;

  // Live compare: lowering dwell mid-state steps at once.
  assign hit  = (cnt_q >= dwell);
  assign step = en & hit & ~clear;

  // Next count: clear wins, then step/increment, else hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      if (hit) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + DWELL_W'(1);
      end
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/param_seq_fsm.sv
// param_seq_fsm: cyclic up/down state sequencer with
// programmable dwell, load/jump and illegal-state recovery.
module param_seq_fsm
  import param_seq_fsm_pkg::*;
#(
  parameter int unsigned NUM_STATES  = 3,
  parameter int unsigned RESET_STATE = 0,
  parameter int unsigned DWELL_W     = 4,
  localparam int unsigned SW =
    (NUM_STATES > 2) ? $clog2(NUM_STATES) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               dir,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               load,
  input  logic [SW-1:0]      load_state,
  input  logic               clr_err,
  output logic [SW-1:0]      state,
  output logic               wrap,
  output logic               err
);

  localparam logic [SW-1:0] RST_S = SW'(RESET_STATE);

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_RECOVER,
    ACT_LOAD_OK,
    ACT_LOAD_BAD,
    ACT_STEP
  } act_e;

  logic [SW-1:0] state_q;
  logic [SW-1:0] state_d;
  logic          wrap_q;
  logic          wrap_d;
  logic          err_q;
  logic          err_d;

  logic          illegal;
  logic          load_bad;
  logic          step;
  logic          cnt_clr;
  seq_step_t     nx;
  act_e          act;
  logic          unused_nx;

  assign illegal  = (32'(state_q) >= NUM_STATES);
  assign load_bad = (32'(load_state) >= NUM_STATES);
  assign cnt_clr  = illegal | load;

  assign nx = next_state(
    32'(state_q),
    seq_dir_e'(dir),
    NUM_STATES
  );
  assign unused_nx = ^nx;

  seq_dwell_counter #(
    .DWELL_W (DWELL_W)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clear (cnt_clr),
    .dwell (dwell),
    .step  (step)
  );

  // Resolve which action wins this cycle, by priority.
  always_comb begin
    act = ACT_HOLD;
    if (illegal) begin
      act = ACT_RECOVER;
    end else if (load) begin
      act = load_bad ? ACT_LOAD_BAD : ACT_LOAD_OK;
    end else if (step) begin
      act = ACT_STEP;
    end
  end

  // Next state, wrap strobe and sticky error.
  always_comb begin
    state_d = state_q;
    wrap_d  = 1'b0;
    err_d   = err_q & ~clr_err;
    unique case (act)
      ACT_RECOVER: begin
        state_d = RST_S;
        err_d   = 1'b1;
      end
      ACT_LOAD_OK: begin
        state_d = load_state;
      end
      ACT_LOAD_BAD: begin
        state_d = RST_S;
        err_d   = 1'b1;
      end
      ACT_STEP: begin
        state_d = nx.idx[SW-1:0];
        wrap_d  = nx.wrap;
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_S;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign state = state_q;
  assign wrap  = wrap_q;
  assign err   = err_q;

endmodule

// File: tb/tb_param_seq_fsm.sv
// tb_param_seq_fsm: directed stimulus with a queue
// scoreboard for 3-state and 5-state sequencers.
module tb_param_seq_fsm;

  logic clk;
  logic rst_n;

  logic       en3, dir3, load3, clr3;
  logic [3:0] dw3;
  logic [1:0] ls3;
  logic [1:0] st3;
  logic       wr3, er3;

  logic       en5, dir5, load5, clr5;
  logic [3:0] dw5;
  logic [2:0] ls5;
  logic [2:0] st5;
  logic       wr5, er5;

  typedef struct {
    int         id;
    logic [2:0] st;
    logic       w;
    logic       e;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   checks;
  int   failures;
  event sample_ev;

  param_seq_fsm #(
    .NUM_STATES  (3),
    .RESET_STATE (0),
    .DWELL_W     (4)
  ) dut3 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en3),
    .dir        (dir3),
    .dwell      (dw3),
    .load       (load3),
    .load_state (ls3),
    .clr_err    (clr3),
    .state      (st3),
    .wrap       (wr3),
    .err        (er3)
  );

  param_seq_fsm #(
    .NUM_STATES  (5),
    .RESET_STATE (0),
    .DWELL_W     (4)
  ) dut5 (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en5),
    .dir        (dir5),
    .dwell      (dw5),
    .load       (load5),
    .load_state (ls5),
    .clr_err    (clr5),
    .state      (st5),
    .wrap       (wr5),
    .err        (er5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(
    input int id, input int s,
    input logic w, input logic e,
    input string tag
  );
    exp_t x;
    x.id  = id;
    x.st  = 3'(s);
    x.w   = w;
    x.e   = e;
    x.tag = tag;
    q.push_back(x);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string tag, input string f,
    input int got, input int exp
  );
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s.%s got=%0d exp=%0d",
               tag, f, got, exp);
    end
  endtask

  // Monitor: drain and compare whenever outputs settle.
  initial begin
    exp_t x;
    logic [2:0] s;
    logic       w, e;
    forever begin
      @(posedge clk or sample_ev);
      #2;
      while (q.size() > 0) begin
        x = q.pop_front();
        if (x.id == 3) begin
          s = {1'b0, st3};
          w = wr3;
          e = er3;
        end else begin
          s = st5;
          w = wr5;
          e = er5;
        end
        chk(x.tag, "state", int'(s), int'(x.st));
        chk(x.tag, "wrap", int'(w), int'(x.w));
        chk(x.tag, "err", int'(e), int'(x.e));
      end
    end
  end

  int t2s [15] = '{0,0,4,4,4,3,3,3,2,2,2,1,1,1,0};
  int t5s [7]  = '{1,1,1,2,2,2,3};
  int t4s [4]  = '{2,1,0,2};

  initial begin
    checks   = 0;
    failures = 0;
    rst_n = 1'b0;
    en3 = 0; dir3 = 0; load3 = 0; clr3 = 0;
    dw3 = 0; ls3 = 0;
    en5 = 0; dir5 = 0; load5 = 0; clr5 = 0;
    dw5 = 0; ls5 = 0;

    cyc();
    push(3, 0, 0, 0, "rst3");
    push(5, 0, 0, 0, "rst5");
    rst_n = 1'b1;

    // Up count, dwell 0, three states.
    en3 = 1; dir3 = 0; dw3 = 0;
    for (int i = 0; i < 7; i++) begin
      cyc();
      push(3, (i + 1) % 3,
           ((i + 1) % 3) == 0, 0, "up3");
    end
    en3 = 0;

    // Down count, dwell 2, five states.
    en5 = 1; dir5 = 1; dw5 = 2;
    for (int k = 0; k < 15; k++) begin
      cyc();
      push(5, t2s[k], k == 2, 0, "dn5");
    end
    cyc();
    push(5, 0, 0, 0, "dn5mid");
    en5 = 0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      push(5, 0, 0, 0, "frz5");
    end
    en5 = 1;
    cyc();
    push(5, 0, 0, 0, "resume5");
    cyc();
    push(5, 4, 1, 0, "resume5wrap");
    en5 = 0;

    // Loads and the sticky error.
    load5 = 1; ls5 = 3;
    cyc(); push(5, 3, 0, 0, "ld3");
    ls5 = 4;
    cyc(); push(5, 4, 0, 0, "ld4");
    ls5 = 6;
    cyc(); push(5, 0, 0, 1, "ld6");
    clr5 = 1; ls5 = 7;
    cyc(); push(5, 0, 0, 1, "ld7clr");
    load5 = 0;
    cyc(); push(5, 0, 0, 0, "clr");
    clr5 = 0;
    load5 = 1; ls5 = 5;
    cyc(); push(5, 0, 0, 1, "ld5");
    load5 = 0; clr5 = 1;
    cyc(); push(5, 0, 0, 0, "clr2");
    clr5 = 0;

    // Dwell lowered mid-count.
    en5 = 1; dir5 = 0; dw5 = 7;
    for (int k = 0; k < 5; k++) begin
      cyc();
      push(5, 0, 0, 0, "dw7");
    end
    dw5 = 2;
    for (int k = 0; k < 7; k++) begin
      cyc();
      push(5, t5s[k], 0, 0, "dw2");
    end
    en5 = 0;

    // Illegal state on the 3-state ring.
    force dut3.state_q = 2'd3;
    load3 = 1; ls3 = 2;
    @(negedge clk);
    release dut3.state_q;
    cyc();
    push(3, 0, 0, 1, "illegal");
    load3 = 0; clr3 = 1; en3 = 1; dir3 = 1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      clr3 = 0;
      push(3, t4s[k], k == 0 || k == 3,
           0, "dn3");
    end
    en3 = 0;

    // Async reset mid-dwell with err set.
    load5 = 1; ls5 = 7;
    cyc(); push(5, 0, 0, 1, "preA");
    ls5 = 3;
    cyc(); push(5, 3, 0, 1, "preB");
    load5 = 0; en5 = 1; dw5 = 5;
    cyc(); push(5, 3, 0, 1, "preC");
    #2;
    rst_n = 1'b0;
    #1;
    push(5, 0, 0, 0, "arst5");
    push(3, 0, 0, 0, "arst3");
    ->sample_ev;
    #3;
    rst_n = 1'b1;
    en5 = 0;

    cyc();
    cyc();
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0",
               q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/param_seq_fsm.md
Name: param_seq_fsm

Overview:
- Parametrised cyclic state sequencer. It is the successor of the fixed three-state ring FSM.
- Steps through NUM_STATES encoded states, either up or down, with a programmable dwell per state.
- Supports a synchronous load/jump and recovers from illegal encodings.
- Feeds control-path blocks that need a free-running or gated phase index, plus a wrap strobe.

Parameters:
- NUM_STATES, 3, number of legal states (0..NUM_STATES-1); must be >= 2.
- RESET_STATE, 0, state entered on reset and on illegal-state recovery; must be < NUM_STATES.
- DWELL_W, 4, width of the dwell programming input and of the internal dwell counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- en  in  1  advance enable; 0 freezes both the state and the dwell counter.
- dir  in  1  0 = count up, 1 = count down.
- dwell  in  DWELL_W  extra cycles to hold each state; 0 = advance every enabled cycle.
- load  in  1  synchronous jump request.
- load_state  in  SW  jump target. SW = max(1, $clog2(NUM_STATES)).
- clr_err  in  1  clears err.
- state  out  SW  current state, registered.
- wrap  out  1  one-cycle pulse, registered.
- err  out  1  sticky error flag, registered.

Behaviour:
- Reset (asynchronous, rst_n=0): state=RESET_STATE, dwell_cnt=0, wrap=0, err=0. Reset mid-dwell or mid-load discards all progress.
- All outputs are registered. There is no combinational path from any input to any output.
- Priority, highest first: illegal-state recovery, then load, then advance, then hold.
- Illegal state (state >= NUM_STATES, reachable only by upset when NUM_STATES is not a power of 2):
  - next cycle state=RESET_STATE, dwell_cnt=0, err=1, wrap=0;
  - applies regardless of en and load.
- Load (load=1), independent of en:
  - if load_state < NUM_STATES: state=load_state next cycle;
  - otherwise: state=RESET_STATE and err=1;
  - in both cases dwell_cnt=0 and wrap=0.
- Advance (en=1, no load):
  - if dwell_cnt >= dwell: the state steps and dwell_cnt clears to 0;
  - otherwise dwell_cnt increments.
  - The compare uses the live dwell value, so lowering dwell mid-state advances on the next enabled cycle.
- Step rules:
  - up: NUM_STATES-1 goes to 0;
  - down: 0 goes to NUM_STATES-1;
  - otherwise +1 or -1.
  - dir is sampled only on the advancing cycle.
- wrap:
  - 1 in exactly the cycle in which state first shows the wrapped value (0 after an up-wrap, NUM_STATES-1 after a down-wrap);
  - 0 in every other cycle, including after a load or recovery that lands on those values.
- Latency: with dwell=D held constant and en=1, each state is held for D+1 cycles.
- en=0 holds state and dwell_cnt; wrap drops to 0.
- err:
  - set by an illegal state or an out-of-range load;
  - cleared by clr_err;
  - a set and a clear in the same cycle: set wins.
- dwell_cnt saturation is impossible, because it never exceeds dwell, whose maximum is 2^DWELL_W-1.

Decomposition:
- Package param_seq_fsm_pkg holds:
  - enum seq_dir_e {DIR_UP, DIR_DOWN};
  - a function next_state(cur, dir, num_states) returning the stepped index and a wrap bit.
- One natural sub-module, seq_dwell_counter:
  - inputs en, clear, dwell;
  - output step.
- The top level owns the state register, priority logic, wrap and err.

Test Plan:
1. NUM_STATES=3, dwell=0, en=1, dir=0 after reset → state 0,1,2,0,1… every cycle; wrap=1 on each cycle where state=0 (from the 2nd visit onward); err=0.
2. NUM_STATES=5, dwell=2, dir=1 → each state held 3 cycles, sequence 0,4,3,2,1,0; wrap=1 in the first cycle of state 4 only. Then toggle en low for 4 cycles mid-dwell → state and remaining dwell are preserved.
3. load=1, load_state=3 with en=0 → state=3 next cycle, wrap=0. Then load_state=6 (NUM_STATES=5) → state=RESET_STATE, err=1. clr_err together with a new bad load → err stays 1. clr_err alone → err=0.
4. Force the state register to 3 with NUM_STATES=3 → next cycle state=0, err=1, wrap=0, even with load=1 the same cycle.
5. dwell=7 mid-count at dwell_cnt=5, then change dwell to 2 → advance on the next enabled cycle; subsequent states held 3 cycles.
6. Assert rst_n=0 asynchronously mid-cycle during dwell, with err=1 → outputs return to state=RESET_STATE, wrap=0, err=0 immediately, without waiting for a clock edge.
